// File: rtl/fir_symmetric_mc.sv
// Symmetric (linear-phase) FIR with per-channel delay lines sharing one pre-add MAC.
// One folded tap pair is accumulated per cycle, so a result appears HALF cycles after the accept.
module fir_symmetric_mc #(
  parameter int DATA_W   = 8,
  parameter int COEF_W   = 9,
  parameter int NUM_TAPS = 22,
  parameter int NUM_CH   = 2,
  parameter int ACC_W    = DATA_W + 1 + COEF_W + $clog2(NUM_TAPS / 2),
  localparam int HALF    = NUM_TAPS / 2,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int AW      = (HALF > 1) ? $clog2(HALF) : 1
) (
  input  logic                     CLK_Filter,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH_W-1:0]          in_ch,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     coef_we,
  input  logic [AW-1:0]            coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     out_valid,
  output logic [CH_W-1:0]          out_ch,
  output logic signed [ACC_W-1:0]  out_data
);

  localparam int TW    = $clog2(NUM_TAPS);
  localparam int PW    = DATA_W + 2 + COEF_W;
  localparam int EXT_W = (ACC_W > PW) ? ACC_W : PW;

  typedef enum logic {S_IDLE = 1'b0, S_ACCUM = 1'b1} state_t;

  // Narrow accumulators wrap in two's complement; wide ones sign-extend the product.
  function automatic logic signed [ACC_W-1:0] wrap_acc(input logic signed [PW-1:0] v);
    logic signed [EXT_W-1:0] ext;
    ext = EXT_W'(v);
    return ext[ACC_W-1:0];
  endfunction

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [NUM_TAPS-1:0][DATA_W-1:0] r_line [NUM_CH];
  logic [HALF-1:0][COEF_W-1:0]     r_coef;
  logic signed [ACC_W-1:0]         r_acc;
  logic [AW-1:0]                   r_k;
  logic [CH_W-1:0]                 r_ch;

  logic                            w_accept;
  logic                            w_coef_wr;
  logic                            w_last;
  logic [TW-1:0]                   w_idx_lo;
  logic [TW-1:0]                   w_idx_hi;
  logic [DATA_W-1:0]               w_tap_lo;
  logic [DATA_W-1:0]               w_tap_hi;
  logic [DATA_W:0]                 w_pre;
  logic signed [PW-1:0]            w_prod;
  logic signed [ACC_W-1:0]         w_term;
  logic signed [ACC_W-1:0]         w_acc_sum;

  assign in_ready  = (r_state == S_IDLE);
  assign w_accept  = (r_state == S_IDLE) && in_valid &&
                     ({1'b0, in_ch} < (CH_W + 1)'(NUM_CH));
  assign w_coef_wr = (r_state == S_IDLE) && coef_we &&
                     ({1'b0, coef_addr} < (AW + 1)'(HALF));
  assign w_last    = (r_k == AW'(HALF - 1));

  // Folded pair k combines tap k with its mirror NUM_TAPS-1-k.
  assign w_idx_lo  = TW'(r_k);
  assign w_idx_hi  = TW'(NUM_TAPS - 1) - TW'(r_k);
  assign w_tap_lo  = r_line[r_ch][w_idx_lo];
  assign w_tap_hi  = r_line[r_ch][w_idx_hi];
  assign w_pre     = {1'b0, w_tap_lo} + {1'b0, w_tap_hi};
  assign w_prod    = PW'($signed({1'b0, w_pre})) * PW'($signed(r_coef[r_k]));
  assign w_term    = wrap_acc(w_prod);
  assign w_acc_sum = r_acc + w_term;

  always_ff @(posedge CLK_Filter or posedge rst_n) begin
    if (rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_ACCUM;
      S_ACCUM: if (w_last)   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_Filter or posedge rst_n) begin
    if (rst_n) begin
      for (int c = 0; c < NUM_CH; c++) r_line[c] <= '0;
      r_coef    <= '0;
      r_acc     <= '0;
      r_k       <= '0;
      r_ch      <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
    end else begin
      out_valid <= 1'b0;
      // A coefficient written in the accept cycle is already in place for the first MAC step.
      if (w_coef_wr) r_coef[coef_addr] <= coef_data;
      if (w_accept) begin
        r_line[in_ch] <= {r_line[in_ch][NUM_TAPS-2:0], in_data};
        r_ch          <= in_ch;
        r_acc         <= '0;
        r_k           <= '0;
      end
      if (r_state == S_ACCUM) begin
        r_acc <= w_acc_sum;
        r_k   <= r_k + AW'(1);
        if (w_last) begin
          out_data  <= w_acc_sum;
          out_ch    <= r_ch;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_symmetric_mc.sv
// Bench for fir_symmetric_mc: a full-length convolution model predicts every result and its
// cycle, a negedge process compares the DUT against it, and literal values pin the model.
module tb_fir_symmetric_mc;
  localparam int DATA_W   = 8;
  localparam int COEF_W   = 9;
  localparam int NUM_TAPS = 22;
  localparam int NUM_CH   = 3;
  localparam int HALF     = NUM_TAPS / 2;
  localparam int ACC_W    = DATA_W + 1 + COEF_W + $clog2(HALF);
  localparam int CH_W     = 2;
  localparam int AW       = 4;

  logic                     clk       = 1'b0;
  logic                     rst       = 1'b1;
  logic                     in_valid  = 1'b0;
  logic [CH_W-1:0]          in_ch     = '0;
  logic [DATA_W-1:0]        in_data   = '0;
  logic                     coef_we   = 1'b0;
  logic [AW-1:0]            coef_addr = '0;
  logic signed [COEF_W-1:0] coef_data = '0;
  logic                     in_ready;
  logic                     out_valid;
  logic [CH_W-1:0]          out_ch;
  logic signed [ACC_W-1:0]  out_data;

  int n_cmp = 0;
  int n_bad = 0;

  fir_symmetric_mc #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .NUM_TAPS(NUM_TAPS), .NUM_CH(NUM_CH), .ACC_W(ACC_W)
  ) dut (
    .CLK_Filter(clk), .rst_n(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {int due; longint data; int ch;} exp_t;
  exp_t   eq[$];
  longint mlog[$];
  int     mlog_ch[$];
  int     acc_cyc[$];
  int     hist [NUM_CH][NUM_TAPS];
  int     coef [HALF];
  int     busy = 0;
  int     cyc  = 0;
  bit     m_idle;
  longint m_sum;
  exp_t   m_e;
  longint last_d  = 0;
  int     last_ch = 0;

  function automatic longint wrap(input longint s);
    logic signed [ACC_W-1:0] w;
    w = s[ACC_W-1:0];
    return longint'(w);
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++)
        for (int j = 0; j < NUM_TAPS; j++) hist[c][j] = 0;
      for (int k = 0; k < HALF; k++) coef[k] = 0;
      eq.delete();
      busy    = 0;
      last_d  = 0;
      last_ch = 0;
    end else begin
      cyc++;
      m_idle = (busy == 0);
      if (!m_idle) busy--;
      if (m_idle && coef_we && coef_addr < HALF) coef[coef_addr] = int'(coef_data);
      if (m_idle && in_valid && in_ch < NUM_CH) begin
        for (int j = NUM_TAPS - 1; j > 0; j--) hist[in_ch][j] = hist[in_ch][j-1];
        hist[in_ch][0] = int'(in_data);
        m_sum = 0;
        for (int j = 0; j < NUM_TAPS; j++)
          m_sum += longint'(coef[(j < NUM_TAPS - 1 - j) ? j : NUM_TAPS - 1 - j]) * hist[in_ch][j];
        m_e.due  = cyc + HALF;
        m_e.data = wrap(m_sum);
        m_e.ch   = int'(in_ch);
        eq.push_back(m_e);
        mlog.push_back(m_e.data);
        mlog_ch.push_back(int'(in_ch));
        acc_cyc.push_back(cyc);
        busy = HALF;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit ev;
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("in_ready", in_ready, busy == 0);
      ev = (eq.size() > 0 && eq[0].due == cyc);
      chk("out_valid", out_valid, ev);
      if (ev) begin
        last_d  = eq[0].data;
        last_ch = eq[0].ch;
        eq.pop_front();
      end
      chk("out_data", $signed(out_data), last_d);
      chk("out_ch", out_ch, last_ch);
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input int ch, input int d, input bit we, input int addr, input int cv);
    bit r;
    bit done;
    in_valid  = 1'b1;
    in_ch     = CH_W'(ch);
    in_data   = DATA_W'(d);
    coef_we   = we;
    coef_addr = AW'(addr);
    coef_data = COEF_W'(cv);
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      r = in_ready;
      @(negedge clk);
      done = r;
    end
    if (!done) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
    coef_we  = 1'b0;
  endtask

  task automatic wcoef(input int a, input int v);
    coef_we   = 1'b1;
    coef_addr = AW'(a);
    coef_data = COEF_W'(v);
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    if (!in_ready) chk("idle_timeout", 0, 1);
  endtask

  task automatic load_ramp();
    wait_idle();
    for (int k = 0; k < HALF; k++) wcoef(k, k + 1);
  endtask

  task automatic load_const(input int v);
    wait_idle();
    for (int k = 0; k < HALF; k++) wcoef(k, v);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", $signed(out_data), 0);
    chk("rst_out_ch", out_ch, 0);

    // Impulse response through the ramp table
    load_ramp();
    mlog.delete();
    send(0, 100, 0, 0, 0);
    for (int i = 0; i < NUM_TAPS; i++) send(0, 0, 0, 0, 0);
    wait_idle();
    chk("impulse_count", mlog.size(), NUM_TAPS + 1);
    if (mlog.size() == NUM_TAPS + 1) begin
      for (int i = 0; i < NUM_TAPS; i++)
        chk("impulse", mlog[i], 100 * ((i < HALF) ? i + 1 : NUM_TAPS - i));
      chk("impulse_tail", mlog[NUM_TAPS], 0);
    end

    // Channel isolation
    mlog.delete();
    mlog_ch.delete();
    for (int i = 0; i < NUM_TAPS; i++) begin
      send(0, 255, 0, 0, 0);
      send(1, 0, 0, 0, 0);
    end
    wait_idle();
    for (int i = 0; i < mlog.size(); i++)
      if (mlog_ch[i] == 1) chk("iso_ch1", mlog[i], 0);
    chk("iso_ch0_final", mlog[2 * NUM_TAPS - 2], 33660);

    // Extremes
    load_const(255);
    for (int i = 0; i < NUM_TAPS; i++) send(0, 255, 0, 0, 0);
    wait_idle();
    chk("ext_pos", mlog[$], 1430550);
    load_const(-256);
    for (int i = 0; i < NUM_TAPS; i++) send(0, 255, 0, 0, 0);
    wait_idle();
    chk("ext_neg", mlog[$], -1436160);

    // Handshake: back-to-back accepts, then a dropped out-of-range channel
    acc_cyc.delete();
    for (int i = 0; i < 4; i++) send(0, 255, 0, 0, 0);
    for (int i = 1; i < 4; i++) chk("accept_spacing", acc_cyc[i] - acc_cyc[i-1], 12);
    wait_idle();
    n = mlog.size();
    send(3, 77, 0, 0, 0);
    chk("drop_ready", in_ready, 1);
    repeat (15) @(negedge clk);
    chk("drop_nolog", mlog.size(), n);

    // Coefficient writes: ignored while busy, used at once in the accept cycle
    load_ramp();
    send(0, 10, 0, 0, 0);
    wcoef(0, 50);
    wait_idle();
    chk("coef_busy_ignored", mlog[$], 33415);
    send(0, 10, 1, 0, 50);
    wait_idle();
    chk("coef_same_cycle", mlog[$], 45910);

    // Reset in the middle of an accumulation
    send(0, 100, 0, 0, 0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", in_ready, 1);
    chk("midrst_out_data", $signed(out_data), 0);
    repeat (15) @(negedge clk);
    send(0, 100, 0, 0, 0);
    wait_idle();
    chk("midrst_zero_coef", mlog[$], 0);
    load_ramp();
    send(0, 100, 0, 0, 0);
    wait_idle();
    chk("midrst_reload", mlog[$], 300);

    // Randomised traffic
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 9) < 2)
        wcoef($urandom_range(0, 15), $urandom_range(0, 511));
      else
        send($urandom_range(0, 3), $urandom_range(0, 255), 1'($urandom_range(0, 3) == 0),
             $urandom_range(0, 15), $urandom_range(0, 511));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    chk("drain", eq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
